// File: rtl/mem_if_pkg.sv
// Shared definitions for the line-granular cache/memory interface.
// Request type encodings and the responder state type.
package mem_if_pkg;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } resp_state;

endpackage

// File: rtl/req_fifo.sv
// In-order queue of pending read line addresses.
// Extra pointer bit distinguishes full from empty; `last` flags a single entry.
module req_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic             last,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0]   wr_q;
    logic [PTR_W:0]   rd_q;
    logic [PTR_W:0]   level;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign level = wr_q - rd_q;
    assign empty = (level == '0);
    assign full  = (level == LVL_FULL);
    assign last  = (level == LVL_ONE);
    assign head  = mem_q[rd_q[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/line_mem_responder.sv
// Memory end of the cache line interface: single-cycle writes, in-order reads
// returned after a fixed latency and held until acknowledged.
module line_mem_responder
    import mem_if_pkg::*;
#(
    parameter int N_ELEMENTS  = 4,
    parameter int N_BYTES     = 4,
    parameter int PA_WIDTH    = 16,
    parameter int N_MEM_LINES = 256,
    parameter int LATENCY     = 4,
    parameter int RQ_DEPTH    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_mem_enable,
    input  logic                                i_mem_type,
    input  logic [PA_WIDTH-1:0]                 i_mem_addr,
    input  logic [N_ELEMENTS*N_BYTES*8-1:0]     i_mem_data,
    input  logic                                i_mem_ack,
    output logic                                o_mem_enable,
    output logic [PA_WIDTH-1:0]                 o_mem_addr,
    output logic [N_ELEMENTS*N_BYTES*8-1:0]     o_mem_data,
    output logic                                o_overflow,
    output logic                                o_busy
);

    localparam int OFFSET_WIDTH = $clog2(N_ELEMENTS);
    localparam int LINE_WIDTH   = N_ELEMENTS*N_BYTES*8;
    localparam int LIDX_WIDTH   = $clog2(N_MEM_LINES);
    localparam int TAG_W        = PA_WIDTH - OFFSET_WIDTH;
    localparam int CNT_W        = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [LINE_WIDTH-1:0] store_q [N_MEM_LINES];

    resp_state        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;

    logic             rd_req, wr_req, push, pop;
    logic             fifo_full, fifo_empty, fifo_last;
    logic [TAG_W-1:0] fifo_head;
    logic             unused_offset_bits;

    assign rd_req = i_mem_enable && (i_mem_type == MEM_READ);
    assign wr_req = i_mem_enable && (i_mem_type == MEM_WRITE);
    assign pop    = (state_q == R_RESP) && i_mem_ack;
    // A full queue still accepts a read when the head retires on the same edge.
    assign push   = rd_req && (!fifo_full || pop);

    assign unused_offset_bits = ^i_mem_addr[OFFSET_WIDTH-1:0];

    req_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (RQ_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (i_mem_addr[PA_WIDTH-1:OFFSET_WIDTH]),
        .full  (fifo_full),
        .empty (fifo_empty),
        .last  (fifo_last),
        .head  (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (wr_req) store_q[i_mem_addr[OFFSET_WIDTH+LIDX_WIDTH-1:OFFSET_WIDTH]] <= i_mem_data;
    end

    // Latency runs from the accepting edge (or ack edge), so IDLE reacts to a push directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        unique case (state_q)
            R_IDLE: begin
                if (!fifo_empty || push) begin
                    state_d = R_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            R_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = R_RESP;
                    vld_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            R_RESP: begin
                if (i_mem_ack) begin
                    vld_d = 1'b0;
                    if (!fifo_last || push) begin
                        state_d = R_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = R_IDLE;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign ovf_d = ovf_q || (rd_req && fifo_full && !pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_mem_enable = vld_q;
    assign o_mem_addr   = {fifo_head, {OFFSET_WIDTH{1'b0}}};
    assign o_mem_data   = store_q[fifo_head[LIDX_WIDTH-1:0]];
    assign o_overflow   = ovf_q;
    assign o_busy       = !fifo_empty || vld_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized and directed bench for line_mem_responder against a queue-based
// reference: a read's response is due LATENCY edges after max(accept, previous ack).
module tb_line_mem_responder;
    import mem_if_pkg::*;

    localparam int LAT = 4;
    localparam int LW  = 128;
    localparam int PAW = 16;
    localparam int QD  = 4;
    localparam int WAIT_MAX = 20;
    localparam logic [LW-1:0] D_A5   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5;
    localparam logic [LW-1:0] D_DEAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_mem_enable, i_mem_type, i_mem_ack;
    logic [PAW-1:0] i_mem_addr;
    logic [LW-1:0]  i_mem_data;
    logic           o_mem_enable, o_overflow, o_busy;
    logic [PAW-1:0] o_mem_addr;
    logic [LW-1:0]  o_mem_data;

    always #5 clk = ~clk;

    line_mem_responder #(
        .N_ELEMENTS (4), .N_BYTES (4), .PA_WIDTH (PAW),
        .N_MEM_LINES (256), .LATENCY (LAT), .RQ_DEPTH (QD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mem_enable (i_mem_enable),
        .i_mem_type   (i_mem_type),
        .i_mem_addr   (i_mem_addr),
        .i_mem_data   (i_mem_data),
        .i_mem_ack    (i_mem_ack),
        .o_mem_enable (o_mem_enable),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending line addresses with their accept edges.
    logic [13:0]   mq[$];
    int            mq_t[$];
    int            last_ack;
    int            edge_n;
    bit            m_vld, m_ovf;
    logic [LW-1:0] mstore [256];

    function automatic bit vld_due();
        int r;
        if (mq.size() == 0) return 1'b0;
        r = ((mq_t[0] > last_ack) ? mq_t[0] : last_ack) + LAT;
        return edge_n >= r;
    endfunction

    task automatic model_reset();
        mq.delete();
        mq_t.delete();
        last_ack = -1000;
        edge_n   = 0;
        m_vld    = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic check_outs();
        chk("valid", o_mem_enable, m_vld);
        chk("overflow", o_overflow, m_ovf);
        chk("busy", o_busy, mq.size() != 0);
        if (m_vld && o_mem_enable) begin
            chk("resp_addr", o_mem_addr, {mq[0], 2'b00});
            chk("resp_data", o_mem_data, mstore[mq[0][7:0]]);
        end
    endtask

    task automatic step(input logic en, input logic typ, input logic [PAW-1:0] addr,
                        input logic [LW-1:0] data, input logic ack);
        i_mem_enable = en;
        i_mem_type   = typ;
        i_mem_addr   = addr;
        i_mem_data   = data;
        i_mem_ack    = ack;
        @(posedge clk);
        edge_n++;
        if (m_vld && ack) begin
            void'(mq.pop_front());
            void'(mq_t.pop_front());
            last_ack = edge_n;
        end
        if (en && typ == MEM_READ) begin
            if (mq.size() < QD) begin
                mq.push_back(addr[15:2]);
                mq_t.push_back(edge_n);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (en && typ == MEM_WRITE) mstore[addr[9:2]] = data;
        m_vld = vld_due();
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle(input logic ack);
        step(1'b0, MEM_READ, '0, '0, ack);
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        while (!o_mem_enable && n < WAIT_MAX) begin
            idle(1'b0);
            n++;
        end
    endtask

    initial begin
        int n;
        logic          en, typ, ack;
        logic [PAW-1:0] a;
        logic [LW-1:0]  d;

        rst = 1'b1;
        i_mem_enable = 1'b0; i_mem_type = 1'b0; i_mem_ack = 1'b0;
        i_mem_addr = '0; i_mem_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", o_mem_enable, 1'b0);
        chk("rst_overflow", o_overflow, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++)
            step(1'b1, MEM_WRITE, PAW'(i << 2), {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);

        // Write then read the same line; response exactly LAT edges later.
        step(1'b1, MEM_WRITE, 16'h0040, D_A5, 1'b0);
        step(1'b1, MEM_READ, 16'h0040, '0, 1'b0);
        wait_vld(n);
        chk("lat_first", n, LAT);
        chk("addr_first", o_mem_addr, 16'h0040);
        chk("data_first", o_mem_data, D_A5);
        idle(1'b1);
        chk("vld_after_ack", o_mem_enable, 1'b0);
        chk("busy_after_ack", o_busy, 1'b0);

        // Unaligned read returns the aligned line address.
        step(1'b1, MEM_READ, 16'h0043, '0, 1'b0);
        wait_vld(n);
        chk("unaligned_addr", o_mem_addr, 16'h0040);
        chk("unaligned_data", o_mem_data, D_A5);
        idle(1'b1);

        // Two back-to-back reads; second due LAT edges after first ack.
        step(1'b1, MEM_READ, 16'h0010, '0, 1'b0);
        step(1'b1, MEM_READ, 16'h0020, '0, 1'b0);
        wait_vld(n);
        chk("lat_pair_first", n, LAT - 1);
        chk("pair_addr0", o_mem_addr, 16'h0010);
        idle(1'b1);
        wait_vld(n);
        chk("lat_after_ack", n, LAT);
        chk("pair_addr1", o_mem_addr, 16'h0020);
        idle(1'b1);

        // Write to the held line is visible while valid stays up.
        step(1'b1, MEM_READ, 16'h0080, '0, 1'b0);
        wait_vld(n);
        step(1'b1, MEM_WRITE, 16'h0080, D_DEAD, 1'b0);
        chk("held_data", o_mem_data, D_DEAD);
        chk("held_addr", o_mem_addr, 16'h0080);
        chk("held_valid", o_mem_enable, 1'b1);
        idle(1'b1);

        // Five reads into a four-deep queue: one dropped, overflow sticks.
        for (int i = 0; i < 5; i++) step(1'b1, MEM_READ, PAW'(i * 16), '0, 1'b0);
        chk("ovf_set", o_overflow, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_vld(n);
            chk("ovf_order", o_mem_addr, PAW'(k * 16));
            idle(1'b1);
        end
        wait_vld(n);
        chk("no_fifth_resp", n, WAIT_MAX);
        chk("ovf_sticky", o_overflow, 1'b1);

        // Reset while a read is waiting: nothing comes back, store survives.
        step(1'b1, MEM_READ, 16'h0040, '0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", o_mem_enable, 1'b0);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_ovf", o_overflow, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_vld(n);
        chk("no_resp_after_rst", n, WAIT_MAX);
        step(1'b1, MEM_READ, 16'h0040, '0, 1'b0);
        wait_vld(n);
        chk("store_kept", o_mem_data, D_A5);
        idle(1'b1);

        // Random traffic over 16 aliased lines with random ack behaviour.
        for (int c = 0; c < 3000; c++) begin
            en  = ($urandom_range(0, 1) == 1);
            typ = ($urandom_range(0, 2) == 0) ? MEM_WRITE : MEM_READ;
            a   = {6'($urandom()), 4'b0000, 4'($urandom()), 2'($urandom())};
            d   = {$urandom(), $urandom(), $urandom(), $urandom()};
            ack = o_mem_enable ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            step(en, typ, a, d, ack);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the data cache's line-granular memory interface: it is the memory end of the request / response / ack protocol that the cache drives.
- Writes are accepted and committed in one cycle, which matches the cache's write-buffer assumption.
- Reads are queued in order and returned after a fixed latency. Each returned line and its address are held until the cache acks.
- Used as the backing-memory model in cache testbenches and as the stub below the cache in the core top.

Parameters:
- N_ELEMENTS, 4, elements per line; OFFSET_WIDTH = $clog2(N_ELEMENTS).
- N_BYTES, 4, bytes per element; LINE_WIDTH = N_ELEMENTS*N_BYTES*8.
- PA_WIDTH, 16, physical address width.
- N_MEM_LINES, 256, lines in backing store; LIDX_WIDTH = $clog2(N_MEM_LINES).
- LATENCY, 4, edges from read accept (or from previous ack) to response valid; must be >= 1.
- RQ_DEPTH, 4, read-request queue depth; must be a power of 2 and >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_mem_enable  in  1  request strobe; one request per cycle in which it is high.
- i_mem_type  in  1  1 = write line, 0 = read line.
- i_mem_addr  in  PA_WIDTH  request address.
- i_mem_data  in  LINE_WIDTH  write line data.
- i_mem_ack  in  1  cache has consumed the current response.
- o_mem_enable  out  1  response valid.
- o_mem_addr  out  PA_WIDTH  response line address, offset bits zero.
- o_mem_data  out  LINE_WIDTH  response line data.
- o_overflow  out  1  sticky: a read was dropped because the queue was full.
- o_busy  out  1  queue non-empty or response outstanding.

Behaviour:
- One clock domain: clk. Reset rst is asynchronous and active-high.
- Reset values: o_mem_enable=0, o_overflow=0, o_busy=0, queue empty, counter=0, state=IDLE.
  - Backing store is not reset.
  - o_mem_addr and o_mem_data are don't-care while o_mem_enable=0.
- Line index = addr[OFFSET_WIDTH+LIDX_WIDTH-1:OFFSET_WIDTH]. Higher address bits are ignored, so addresses alias.
- Write handling (i_mem_enable & i_mem_type):
  - store[index] <= i_mem_data at that edge.
  - Never stalled; no response and no ack involved.
- Read handling (i_mem_enable & !i_mem_type):
  - Line address {addr[PA_WIDTH-1:OFFSET_WIDTH], 0} is pushed to the queue.
  - If the queue is full and no pop happens in the same cycle, the request is dropped and o_overflow <= 1 (cleared only by rst).
- Push and pop in the same cycle are legal. Occupancy is unchanged; the full queue is not an overflow in that case.
- FSM:
  - IDLE: if the queue is non-empty, load counter = LATENCY-1 and go to WAIT. If the queue was empty and a read is accepted at edge T, response valid must rise at edge T+LATENCY exactly.
  - WAIT: decrement the counter; at 0 go to RESP and set o_mem_enable <= 1.
  - RESP:
    - o_mem_addr = queue head.
    - o_mem_data = store[head index], read combinationally, so a write to that line while the response is held is visible on the next cycle.
    - On i_mem_ack sampled high: o_mem_enable <= 0, pop the head, and go to WAIT with counter = LATENCY-1 if the queue is still non-empty, else IDLE.
    - The next response rises at ack edge + LATENCY.
- i_mem_ack while not in RESP is ignored.
- Valid is held until ack, with no timeout.
- The cache acks one cycle after it samples valid, so valid stays high for at least 2 cycles. Duplicate sampling by the cache is legal.
- Responses are returned strictly in request order.
- o_busy = queue non-empty | o_mem_enable.
- Reset during WAIT or RESP: pending and held responses are discarded. o_mem_enable drops immediately (asynchronously).

Decomposition:
- Package mem_if_pkg:
  - MEM_READ=1'b0, MEM_WRITE=1'b1.
  - typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} resp_state.
- Sub-module req_fifo:
  - Synchronous FIFO, width PA_WIDTH-OFFSET_WIDTH, depth RQ_DEPTH.
  - Ports: push, pop, full, empty, head; asynchronous reset.
- Top module holds the store array, counter, FSM and overflow flag.

Test Plan (parameters at defaults, LINE_WIDTH=128):
- Write 0x0040 with data 0x...A5 at edge 0, read 0x0040 at edge 1 -> o_mem_enable rises at edge 5, o_mem_addr=0x0040, data=0x...A5; ack sampled at edge 6 -> o_mem_enable=0 after edge 6, o_busy=0.
- Read 0x0043 (unaligned) -> o_mem_addr=0x0040, data=store[0x10 index].
- Reads 0x0010 then 0x0020 on consecutive cycles, each acked 1 cycle after valid -> responses in order; second valid rises exactly 4 edges after first ack edge.
- While response for 0x0080 is held (no ack), write 0x0080 with 0xDEAD... -> o_mem_data shows 0xDEAD... the next cycle; addr unchanged; valid stays 1.
- 5 reads (0x00,0x10,0x20,0x30,0x40) back-to-back with no ack -> o_overflow=1 after 5th accept (sticky); acking yields exactly 4 responses, 0x00..0x30 in order.
- Assert rst for 1 cycle during WAIT of a pending read -> o_mem_enable stays 0, o_busy=0, no response after reset; store contents written before reset still readable.
